// File: rtl/modulo_pagamento_pkg.sv
// Shared types for the coin-payment stage: FSM states, S_PAGAMENTO codes and coin values.
package pagamento_pkg;

   typedef enum logic [1:0] {
      OCIOSO     = 2'd0,
      ACUMULANDO = 2'd1,
      APROVADO   = 2'd2,
      ERRO       = 2'd3
   } estado_t;

   localparam logic [1:0] PAG_PEND = 2'b00;
   localparam logic [1:0] PAG_ERRO = 2'b01;
   localparam logic [1:0] PAG_OK   = 2'b11;

   localparam logic [1:0] BEBIDA_INVALIDA = 2'b11;
   localparam logic [1:0] MOEDA_INVALIDA  = 2'b11;

   // Coin value in units of 25 centavos; the unrecognised code maps to 0.
   function automatic logic [2:0] moeda_valor(input logic [1:0] moeda);
      logic [2:0] valor;
      valor = 3'd0;
      case (moeda)
         2'b00:   valor = 3'd1;
         2'b01:   valor = 3'd2;
         2'b10:   valor = 3'd4;
         default: valor = 3'd0;
      endcase
      return valor;
   endfunction

endpackage

// File: rtl/modulo_pagamento_detector_borda.sv
// Rising-edge detector for HABILITA; the history bit resets high so a level held from reset never arms.
module detector_borda (
   input  logic CLK,
   input  logic RESET_N,
   input  logic sinal_i,
   output logic borda_o
);

   logic sinal_q;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         sinal_q <= 1'b1;
      end else begin
         sinal_q <= sinal_i;
      end
   end

   assign borda_o = sinal_i & ~sinal_q;

endmodule

// File: rtl/modulo_pagamento.sv
// Coin-payment stage feeding the coffee-machine MEF. Define TROCO_EN to allow overpayment with change;
// without it only exact payment is approved and TROCO/TROCO_VALIDO are tied to 0.
module modulo_pagamento
   import pagamento_pkg::*;
#(
   parameter int CRED_W  = 4,
   parameter int PRECO_0 = 6,
   parameter int PRECO_1 = 8,
   parameter int PRECO_2 = 10
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              HABILITA,
   input  logic [1:0]        BEBIDA,
   input  logic              MOEDA_VALIDA,
   input  logic [1:0]        MOEDA,
   output logic [1:0]        S_PAGAMENTO,
   output logic [CRED_W-1:0] CREDITO,
   output logic [CRED_W-1:0] TROCO,
   output logic              TROCO_VALIDO,
   output logic [1:0]        ESTADO_DBG
);

   // MOEDA_VALIDA is a one-cycle strobe with no ready: the coin is taken whenever it is high
   // while collecting with HABILITA high, and silently dropped in every other situation.

   logic              armar;
   estado_t           estado_q;
   logic [1:0]        s_pag_q;
   logic [CRED_W-1:0] credito_q;
   logic [CRED_W-1:0] preco_q;
   logic [CRED_W-1:0] preco_d;
   logic [CRED_W:0]   soma_d;
   logic [CRED_W-1:0] soma_v;
`ifdef TROCO_EN
   logic [CRED_W-1:0] troco_q;
   logic              troco_valido_q;
`endif

   detector_borda u_borda (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .sinal_i (HABILITA),
      .borda_o (armar)
   );

   // One extra bit so a carry out of the credit register is visible as overflow.
   assign soma_d = {1'b0, credito_q} + (CRED_W+1)'(moeda_valor(MOEDA));
   assign soma_v = soma_d[CRED_W-1:0];

   always_comb begin
      preco_d = '0;
      case (BEBIDA)
         2'b00:   preco_d = CRED_W'(PRECO_0);
         2'b01:   preco_d = CRED_W'(PRECO_1);
         2'b10:   preco_d = CRED_W'(PRECO_2);
         default: preco_d = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         estado_q  <= OCIOSO;
         s_pag_q   <= PAG_PEND;
         credito_q <= '0;
         preco_q   <= '0;
`ifdef TROCO_EN
         troco_q        <= '0;
         troco_valido_q <= 1'b0;
`endif
      end else begin
`ifdef TROCO_EN
         troco_valido_q <= 1'b0;
`endif
         if (!HABILITA) begin
            estado_q  <= OCIOSO;
            s_pag_q   <= PAG_PEND;
            credito_q <= '0;
`ifdef TROCO_EN
            troco_q <= '0;
`endif
         end else begin
            case (estado_q)
               OCIOSO: begin
                  if (armar) begin
                     credito_q <= '0;
                     if (BEBIDA == BEBIDA_INVALIDA) begin
                        estado_q <= ERRO;
                        s_pag_q  <= PAG_ERRO;
                     end else begin
                        preco_q  <= preco_d;
                        estado_q <= ACUMULANDO;
                     end
                  end
               end
               ACUMULANDO: begin
                  if (MOEDA_VALIDA) begin
                     if (MOEDA == MOEDA_INVALIDA) begin
                        estado_q <= ERRO;
                        s_pag_q  <= PAG_ERRO;
                     end else if (soma_d[CRED_W]) begin
                        estado_q  <= ERRO;
                        s_pag_q   <= PAG_ERRO;
                        credito_q <= '1;
                     end
`ifdef TROCO_EN
                     else if (soma_v >= preco_q) begin
                        estado_q       <= APROVADO;
                        s_pag_q        <= PAG_OK;
                        credito_q      <= soma_v;
                        troco_q        <= soma_v - preco_q;
                        troco_valido_q <= 1'b1;
                     end
`else
                     else if (soma_v == preco_q) begin
                        estado_q  <= APROVADO;
                        s_pag_q   <= PAG_OK;
                        credito_q <= soma_v;
                     end else if (soma_v > preco_q) begin
                        estado_q  <= ERRO;
                        s_pag_q   <= PAG_ERRO;
                        credito_q <= soma_v;
                     end
`endif
                     else begin
                        credito_q <= soma_v;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign S_PAGAMENTO = s_pag_q;
   assign CREDITO     = credito_q;
   assign ESTADO_DBG  = estado_q;
`ifdef TROCO_EN
   assign TROCO        = troco_q;
   assign TROCO_VALIDO = troco_valido_q;
`else
   assign TROCO        = '0;
   assign TROCO_VALIDO = 1'b0;
`endif

endmodule
